// File: rtl/ks_pkg.sv
// Shared constants and helpers for the Kogge-Stone adder sharing logic.
package ks_pkg;

  localparam int KS_WIDTH   = 16;
  localparam int KS_MAX_REQ = 8;

  function automatic int ks_idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ks_add_arbiter_checker.sv
// Requester-protocol and grant-shape properties for ks_add_arbiter.
module ks_add_arbiter_checker #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic [NREQ-1:0]       req_valid,
  input logic [NREQ-1:0]       req_ready,
  input logic [NREQ*WIDTH-1:0] req_a,
  input logic [NREQ*WIDTH-1:0] req_b,
  input logic [NREQ-1:0]       req_cin
);

  a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));

  for (genvar i = 0; i < NREQ; i++) begin : g_hold
    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (req_valid[i] && !req_ready[i]) |=>
      (req_valid[i] && $stable(req_a[i*WIDTH +: WIDTH]) &&
       $stable(req_b[i*WIDTH +: WIDTH]) && $stable(req_cin[i])));
  end

endmodule

// File: rtl/ks_rr_arbiter.sv
// Round-robin grant selection with its own rotating priority pointer.
module ks_rr_arbiter
  import ks_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = ks_idw(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [IDW-1:0]  ptr_r;
  logic [NREQ-1:0] rot_s;
  logic [IDW-1:0]  off_s;
  logic [IDW:0]    sum_s;
  logic [IDW-1:0]  idx_s;

  // Rotate so the pointer lands on bit 0, take the lowest set bit, then map back.
  always_comb begin
    rot_s = NREQ'({req_valid, req_valid} >> ptr_r);
    off_s = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_s[k]) off_s = IDW'(k);
      else          off_s = off_s;
    end
    sum_s = {1'b0, ptr_r} + {1'b0, off_s};
    if (sum_s >= (IDW+1)'(NREQ)) idx_s = IDW'(sum_s - (IDW+1)'(NREQ));
    else                         idx_s = sum_s[IDW-1:0];
  end

  assign grant     = (|req_valid) ? (NREQ'(1) << idx_s) : '0;
  assign grant_idx = idx_s;

  // Pointer moves just past the winner on every accept, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (advance) begin
      ptr_r <= (idx_s == IDW'(NREQ - 1)) ? '0 : idx_s + IDW'(1);
    end
  end

endmodule

// File: rtl/ks_add_arbiter.sv
// Shares one combinational adder core among NREQ requesters and buffers one result.
module ks_add_arbiter
  import ks_pkg::*;
#(
  parameter  int WIDTH = KS_WIDTH,
  parameter  int NREQ  = 4,
  localparam int IDW   = ks_idw(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [IDW-1:0]        rsp_id
);

  logic [NREQ-1:0]  grant_s;
  logic [IDW-1:0]   grant_idx_s;
  logic             can_accept_s;
  logic             accept_s;
  logic             rsp_valid_r;
  logic [WIDTH-1:0] rsp_sum_r;
  logic             rsp_cout_r;
  logic [IDW-1:0]   rsp_id_r;

  assign can_accept_s = !rsp_valid_r || rsp_ready;
  assign accept_s     = (|req_valid) && can_accept_s;
  assign req_ready    = accept_s ? grant_s : '0;

  ks_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .advance   (accept_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  // AND-OR operand mux; a zero grant vector yields all-zero operands.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      add_a   = add_a | (req_a[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
      add_b   = add_b | (req_b[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
      add_cin = add_cin | (req_cin[i] & grant_s[i]);
    end
  end

  // One-entry response buffer; payload only changes on accept so it holds through stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_sum_r   <= '0;
      rsp_cout_r  <= 1'b0;
      rsp_id_r    <= '0;
    end else if (accept_s) begin
      rsp_valid_r <= 1'b1;
      rsp_sum_r   <= add_sum;
      rsp_cout_r  <= add_cout;
      rsp_id_r    <= grant_idx_s;
    end else if (rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_sum   = rsp_sum_r;
  assign rsp_cout  = rsp_cout_r;
  assign rsp_id    = rsp_id_r;

  ks_add_arbiter_checker #(.WIDTH(WIDTH), .NREQ(NREQ)) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin)
  );

endmodule
